// File: rtl/fft_sequencer_pkg.sv
// Shared FFT control definitions: frame geometry, default butterfly latency,
// and the sequencer state encoding.
package fft_sequencer_pkg;

  localparam int FFT_N_LOG2   = 9;    // 512-point frame
  localparam int FFT_HALF     = 256;  // butterflies per stage at the default length
  localparam int FFT_BFLY_LAT = 2;    // read address to write-back, in cycles

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PROC,
    ST_DRAIN,
    ST_OUT
  } fft_state_e;

  // Butterflies per stage for an arbitrary length.
  function automatic int fft_half(input int n_log2);
    return 1 << (n_log2 - 1);
  endfunction

endpackage

// File: rtl/fft_sequencer_if.sv
// Sequencer handshake/control bus. The master side drives the frame and
// sample handshakes. The slave side (the sequencer) drives the AGU/RAM
// controls.
interface fft_sequencer_if #(
  parameter int N_LOG2 = fft_sequencer_pkg::FFT_N_LOG2
);
  logic              start;
  logic              sample_valid;
  logic              out_ready;
  logic              load;
  logic              processing;
  logic              done;
  logic [N_LOG2-1:0] fft_level;
  logic [N_LOG2-1:0] butterfly_iter;
  logic [N_LOG2-1:0] load_address;
  logic [N_LOG2-1:0] out_address;
  logic              mem_we;
  logic              bank_sel;
  logic              out_valid;
  logic              frame_done;

  modport master (
    output start, sample_valid, out_ready,
    input  load, processing, done, fft_level, butterfly_iter,
           load_address, out_address, mem_we, bank_sel, out_valid, frame_done
  );

  modport slave (
    input  start, sample_valid, out_ready,
    output load, processing, done, fft_level, butterfly_iter,
           load_address, out_address, mem_we, bank_sel, out_valid, frame_done
  );
endinterface

// File: rtl/fft_we_delay.sv
// Write-back strobe generator: delays the butterfly read-issue strobe by the
// datapath latency, so each write lands when its result is available.
module fft_we_delay #(
  parameter int LAT = fft_sequencer_pkg::FFT_BFLY_LAT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_strobe,
  output logic o_strobe
);
  logic [LAT-1:0] r_pipe;
  logic [LAT:0]   w_vld_pipe;

  // Tap 0 is the live issue strobe. Tap LAT is the write-back.
  assign w_vld_pipe = {r_pipe, i_strobe};
  assign o_strobe   = w_vld_pipe[LAT];

  // Shift one tap per cycle. Reset flushes in-flight strobes so that no
  // write-back can follow a reset.
  always_ff @(posedge clk) begin
    if (reset) r_pipe <= '0;
    else       r_pipe <= w_vld_pipe[LAT-1:0];
  end
endmodule

// File: rtl/fft_sequencer.sv
// FFT frame sequencer. The frame goes through these phases in order:
//   1. Load a frame of samples.
//   2. Run N_LOG2 butterfly stages, ping-ponging between RAM banks. Each
//      stage is followed by a drain that lets write-backs land.
//   3. Stream the result out under a ready handshake.
module fft_sequencer
  import fft_sequencer_pkg::*;
#(
  parameter int N_LOG2   = FFT_N_LOG2,
  parameter int BFLY_LAT = FFT_BFLY_LAT
) (
  input logic         clk,
  input logic         reset,
  fft_sequencer_if.slave bus
);
  localparam int                DW         = (BFLY_LAT > 1) ? $clog2(BFLY_LAT) : 1;
  localparam logic [N_LOG2-1:0] ADDR_LAST  = '1;
  localparam logic [N_LOG2-1:0] ITER_LAST  = N_LOG2'(fft_half(N_LOG2) - 1);
  localparam logic [N_LOG2-1:0] LEVEL_LAST = N_LOG2'(N_LOG2 - 1);
  localparam logic [DW-1:0]     DRAIN_LAST = DW'(BFLY_LAT - 1);

  fft_state_e        r_state;
  logic              r_load, r_proc, r_done, r_bank, r_frame_done;
  logic [N_LOG2-1:0] r_level, r_iter, r_load_addr, r_out_addr;
  logic [DW-1:0]     r_drain;
  logic              w_rd_issue, w_wb_we;

  // A butterfly read is issued on every PROC cycle; DRAIN issues none.
  assign w_rd_issue = (r_state == ST_PROC);

  fft_we_delay #(.LAT(BFLY_LAT)) u_we_delay (
    .clk      (clk),
    .reset    (reset),
    .i_strobe (w_rd_issue),
    .o_strobe (w_wb_we)
  );

  // Sequencer FSM; mode outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_load       <= 1'b0;
      r_proc       <= 1'b0;
      r_done       <= 1'b0;
      r_bank       <= 1'b0;
      r_frame_done <= 1'b0;
      r_level      <= '0;
      r_iter       <= '0;
      r_load_addr  <= '0;
      r_out_addr   <= '0;
      r_drain      <= '0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state     <= ST_LOAD;
            r_load      <= 1'b1;
            r_load_addr <= '0;
          end
        end
        ST_LOAD: begin
          if (bus.sample_valid) begin
            if (r_load_addr == ADDR_LAST) begin
              r_state <= ST_PROC;
              r_load  <= 1'b0;
              r_proc  <= 1'b1;
              r_level <= '0;
              r_iter  <= '0;
              r_bank  <= 1'b0;
            end else begin
              r_load_addr <= r_load_addr + 1'b1;
            end
          end
        end
        ST_PROC: begin
          if (r_iter == ITER_LAST) begin
            r_state <= ST_DRAIN;
            r_drain <= '0;
          end else begin
            r_iter <= r_iter + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (r_drain == DRAIN_LAST) begin
            // Every stage ends by flipping to the bank it just wrote.
            // After the final stage this leaves bank_sel on the result.
            r_bank <= ~r_bank;
            if (r_level != LEVEL_LAST) begin
              r_state <= ST_PROC;
              r_level <= r_level + 1'b1;
              r_iter  <= '0;
            end else begin
              r_state    <= ST_OUT;
              r_proc     <= 1'b0;
              r_done     <= 1'b1;
              r_out_addr <= '0;
            end
          end else begin
            r_drain <= r_drain + 1'b1;
          end
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            if (r_out_addr == ADDR_LAST) begin
              r_state      <= ST_IDLE;
              r_done       <= 1'b0;
              r_frame_done <= 1'b1;
            end else begin
              r_out_addr <= r_out_addr + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.load           = r_load;
  assign bus.processing     = r_proc;
  assign bus.done           = r_done;
  assign bus.out_valid      = r_done;
  assign bus.fft_level      = r_level;
  assign bus.butterfly_iter = r_iter;
  assign bus.load_address   = r_load_addr;
  assign bus.out_address    = r_out_addr;
  assign bus.bank_sel       = r_bank;
  assign bus.frame_done     = r_frame_done;
  // Load writes follow the sample strobe directly; butterfly writes come
  // from the delay line.
  assign bus.mem_we         = (r_load & bus.sample_valid) | w_wb_we;
endmodule

// File: doc/fft_sequencer.md
FFT_SEQUENCER -- requirements
Module: fft_sequencer

Interface
REQ-001 Parameter N_LOG2, default 9, log2 of FFT length (512 points).
REQ-002 Parameter BFLY_LAT, default 2, butterfly datapath latency in cycles, read address to write-back.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  request to begin loading a new frame; sampled only in IDLE.
REQ-006 sample_valid  in  1  input sample present this cycle.
REQ-007 out_ready  in  1  consumer accepts the current output sample.
REQ-008 load  out  1  high in LOAD; selects load addressing in the AGU.
REQ-009 processing  out  1  high in PROC and DRAIN.
REQ-010 done  out  1  high in OUT; selects out_address in the AGU.
REQ-011 fft_level  out  9  current butterfly stage, 0..N_LOG2-1.
REQ-012 butterfly_iter  out  9  butterfly index within stage, 0..255.
REQ-013 load_address  out  9  natural-order index of the incoming sample.
REQ-014 out_address  out  9  natural-order index of the output sample.
REQ-015 mem_we  out  1  RAM write strobe: load writes, and butterfly write-backs delayed BFLY_LAT.
REQ-016 bank_sel  out  1  ping-pong bank being read; writes target the other bank during PROC.
REQ-017 out_valid  out  1  output sample at out_address valid.
REQ-018 frame_done  out  1  one-cycle pulse when the last output is accepted.

Function
REQ-019 FSM states IDLE, LOAD, PROC, DRAIN, OUT; exactly one is active.
REQ-020 IDLE->LOAD when start=1; load_address cleared to 0.
REQ-021 In LOAD, mem_we=sample_valid; load_address increments on each sample_valid; no advance without it.
REQ-022 LOAD->PROC on the cycle sample_valid accepts address 511; fft_level=0, butterfly_iter=0, bank_sel=0.
REQ-023 In PROC, butterfly_iter increments every cycle without stalls, 0..255.
REQ-024 PROC->DRAIN after butterfly_iter=255 issues; DRAIN lasts exactly BFLY_LAT cycles, no new reads.
REQ-025 mem_we during PROC/DRAIN equals the read-issue strobe delayed BFLY_LAT cycles; exactly 256 writes per stage.
REQ-026 Leaving DRAIN: if fft_level<N_LOG2-1, fft_level++, butterfly_iter=0, bank_sel toggles, return to PROC; else go to OUT.
REQ-027 In OUT, bank_sel holds the bank last written (N_LOG2 toggles from 0 give 1 for N_LOG2=9); out_valid=1; out_address starts at 0.
REQ-028 out_address advances only when out_valid and out_ready are both high; out_address=511 accepted -> frame_done pulse, go to IDLE.
REQ-029 start during LOAD, PROC, DRAIN, or OUT is ignored.
REQ-030 Counters do not wrap inside a state; each terminal value forces the state transition above.
REQ-031 Total PROC+DRAIN cycles per frame = N_LOG2*(256+BFLY_LAT) (2322 for the defaults).

Reset
REQ-032 reset=1 forces IDLE at the next edge regardless of state, including mid-LOAD and mid-PROC.
REQ-033 Reset values: all counters 0, bank_sel 0, all strobes and mode outputs 0, and the delay pipeline cleared, so no write-back strobe follows reset.

Structure
REQ-034 The state enum, N_LOG2, half-length 256, and default BFLY_LAT belong in the shared FFT package.
REQ-035 One sub-module, fft_we_delay, is a BFLY_LAT-deep shift register that generates the write-back strobe.
REQ-036 Outputs drive fft_agu directly, with no glue logic.

Verification
REQ-037 start, then 512 back-to-back sample_valid -> load_address 0..511, 512 mem_we pulses, PROC entered on the next cycle.
REQ-038 sample_valid every other cycle -> load_address holds during gaps; LOAD lasts 1024 cycles.
REQ-039 Full frame with defaults -> 9 stages, bank_sel ends at 1, 2322 processing cycles, 2304 write-back strobes.
REQ-040 out_ready toggling 1,0,1,0 -> out_address advances only on accepted cycles; frame_done pulses once after address 511.
REQ-041 reset asserted at fft_level=4, butterfly_iter=100 -> next cycle IDLE with all outputs 0; no mem_we appears afterward.
REQ-042 start held high through a whole frame -> exactly one frame processed; a new LOAD begins only from IDLE.
